rom_arbiter: RTL

Two-port round-robin arbiter that shares the single synchronous 16x4 ROM between two read requesters. It accepts one request at a time and drives the ROM `en`/`addr` pins. It then captures `data` after a fixed read latency and returns it to the winning requester with a one-cycle valid pulse. It sits directly in front of the ROM instance; requesters never touch the ROM pins.

---
 rtl/rom_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter sharing one synchronous ROM between two
// read requesters. One transaction in flight at a time. Read data is returned
// to the winning requester with a one-cycle valid pulse.
module rom_arbiter #(
   parameter int AW     = 4,
   parameter int DW     = 4,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic          rom_en,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   // Counter reload: WAIT spends RD_LAT cycles before the capture edge.
   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

   state_t        r_state;
   logic [1:0]    r_cnt;
   logic          r_last;     // 1 = requester 1 was granted last
   logic          r_owner;    // winner of the transaction in flight
   logic          r_gnt0;
   logic          r_gnt1;
   logic          r_rvalid0;
   logic          r_rvalid1;
   logic [DW-1:0] r_rdata;
   logic          r_busy;
   logic          r_rom_en;
   logic [AW-1:0] r_rom_addr;

   logic          w_any;
   logic          w_win;      // 0 = requester 0 wins, 1 = requester 1 wins

   // Round-robin winner select: a lone request wins, a tie goes to the
   // requester that was not granted last.
   always_comb begin
      w_any = req0 | req1;
      w_win = req1;
      if (req0 && req1) begin
         w_win = ~r_last;
      end
   end

   // Arbitration FSM: grant in IDLE, one ROM enable cycle in ISSUE, count down
   // the read latency in WAIT and capture the ROM data on the last count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 2'd0;
         r_last     <= 1'b1;
         r_owner    <= 1'b0;
         r_gnt0     <= 1'b0;
         r_gnt1     <= 1'b0;
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
         r_rdata    <= '0;
         r_busy     <= 1'b0;
         r_rom_en   <= 1'b0;
         r_rom_addr <= '0;
      end else begin
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner    <= w_win;
                  r_last     <= w_win;
                  r_rom_addr <= w_win ? addr1 : addr0;
                  r_rom_en   <= 1'b1;
                  r_gnt0     <= ~w_win;
                  r_gnt1     <= w_win;
                  r_busy     <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_rom_en <= 1'b0;
               r_cnt    <= LAT_LOAD;
               r_state  <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == 2'd0) begin
                  r_rdata   <= rom_data;
                  r_rvalid0 <= ~r_owner;
                  r_rvalid1 <= r_owner;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt0     = r_gnt0;
   assign gnt1     = r_gnt1;
   assign rvalid0  = r_rvalid0;
   assign rvalid1  = r_rvalid1;
   assign rdata    = r_rdata;
   assign busy     = r_busy;
   assign rom_en   = r_rom_en;
   assign rom_addr = r_rom_addr;

endmodule
